// File: rtl/ahb2obi_pkg.sv
// AHB-Lite -> OBI slave adapter: shared encodings and address-phase helpers.
package ahb2obi_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HS_BYTE = 3'd0,
        HS_HALF = 3'd1,
        HS_WORD = 3'd2
    } hsize_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RSP,
        S_DONE,
        S_ERR1,
        S_ERR2
    } state_e;

    // Byte lanes touched by a transfer; anything wider than a word maps to all lanes.
    function automatic logic [3:0] be_decode(input logic [2:0] hsize, input logic [1:0] a);
        case (hsize)
            HS_BYTE: be_decode = 4'b0001 << a;
            HS_HALF: be_decode = 4'b0011 << {a[1], 1'b0};
            default: be_decode = 4'b1111;
        endcase
    endfunction

    // Transfer is naturally aligned and no wider than the 32-bit data bus.
    function automatic logic size_ok(input logic [2:0] hsize, input logic [1:0] a);
        case (hsize)
            HS_BYTE: size_ok = 1'b1;
            HS_HALF: size_ok = ~a[0];
            HS_WORD: size_ok = (a == 2'b00);
            default: size_ok = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb2obi_slave_adapter.sv
// AHB-Lite slave port turned into single outstanding OBI master requests.
// Optional build macro: AHB2OBI_RDATA_REG_EN registers the OBI response before it
// reaches the AHB side (one extra cycle, no obi_rdata_i -> hrdata_o path).
module ahb2obi_slave_adapter
    import ahb2obi_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter bit ERR_UNALIGNED = 1'b1
) (
    input  logic              hclk_i,
    input  logic              hresetn_i,
    input  logic              hsel_i,
    input  logic [ADDR_W-1:0] haddr_i,
    input  logic [1:0]        htrans_i,
    input  logic              hwrite_i,
    input  logic [2:0]        hsize_i,
    input  logic [31:0]       hwdata_i,
    input  logic              hready_i,
    output logic              hreadyout_o,
    output logic              hresp_o,
    output logic [31:0]       hrdata_o,
    output logic              obi_req_o,
    input  logic              obi_gnt_i,
    output logic [ADDR_W-1:0] obi_addr_o,
    output logic              obi_we_o,
    output logic [3:0]        obi_be_o,
    output logic [31:0]       obi_wdata_o,
    input  logic              obi_rvalid_i,
    input  logic [31:0]       obi_rdata_i,
    input  logic              obi_err_i
);

    state_e              r_state;
    logic                r_obi_req;
    logic [ADDR_W-1:0]   r_obi_addr;
    logic                r_obi_we;
    logic [3:0]          r_obi_be;
    logic                r_hresp;
    logic                r_err;
    logic [31:0]         r_hrdata;

    logic                w_accept;
    logic                w_bad;
    logic                w_rsp_ok;
    logic                w_take;

    assign w_accept = hsel_i & hready_i &
                      ((htrans_i == HT_NONSEQ) | (htrans_i == HT_SEQ));
    assign w_bad    = ERR_UNALIGNED & ~size_ok(hsize_i, haddr_i[1:0]);

`ifdef AHB2OBI_RDATA_REG_EN
    assign w_rsp_ok = (r_state == S_DONE) & ~r_err;
    assign hrdata_o = r_hrdata;
`else
    assign w_rsp_ok = (r_state == S_RSP) & obi_rvalid_i & ~obi_err_i;
    // Read data flows straight through on the completing cycle, otherwise holds.
    assign hrdata_o = (w_rsp_ok & ~r_obi_we) ? obi_rdata_i : r_hrdata;
`endif

    // A new address phase is only sampled while our own data phase is idle or finishing.
    assign w_take = w_accept &
                    ((r_state == S_IDLE) | (r_state == S_ERR2) | w_rsp_ok);

    assign hreadyout_o = (r_state == S_IDLE) | (r_state == S_ERR2) | w_rsp_ok;
    assign hresp_o     = r_hresp;
    assign obi_req_o   = r_obi_req;
    assign obi_addr_o  = r_obi_addr;
    assign obi_we_o    = r_obi_we;
    assign obi_be_o    = r_obi_be;
    // The AHB master holds hwdata for the whole (stalled) data phase.
    assign obi_wdata_o = hwdata_i;

    // Transfer FSM; a captured address phase overrides the plain next state.
    always_ff @(posedge hclk_i or negedge hresetn_i) begin
        if (!hresetn_i) begin
            r_state    <= S_IDLE;
            r_obi_req  <= 1'b0;
            r_obi_addr <= '0;
            r_obi_we   <= 1'b0;
            r_obi_be   <= 4'b0000;
            r_hresp    <= 1'b0;
            r_err      <= 1'b0;
            r_hrdata   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE, S_ERR2: begin
                    r_state <= S_IDLE;
                    r_hresp <= 1'b0;
                end
                S_REQ: begin
                    if (obi_gnt_i) begin
                        r_obi_req <= 1'b0;
                        r_state   <= S_RSP;
                    end
                end
                S_RSP: begin
                    if (obi_rvalid_i) begin
                        r_err <= obi_err_i;
                        if (!obi_err_i && !r_obi_we) r_hrdata <= obi_rdata_i;
`ifdef AHB2OBI_RDATA_REG_EN
                        r_state <= S_DONE;
`else
                        if (obi_err_i) begin
                            r_state <= S_ERR1;
                            r_hresp <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (r_err) begin
                        r_state <= S_ERR1;
                        r_hresp <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ERR1:  r_state <= S_ERR2;
                default: r_state <= S_IDLE;
            endcase

            if (w_take) begin
                r_obi_addr <= {haddr_i[ADDR_W-1:2], 2'b00};
                r_obi_we   <= hwrite_i;
                r_obi_be   <= be_decode(hsize_i, haddr_i[1:0]);
                if (w_bad) begin
                    r_state   <= S_ERR1;
                    r_hresp   <= 1'b1;
                    r_obi_req <= 1'b0;
                end else begin
                    r_state   <= S_REQ;
                    r_hresp   <= 1'b0;
                    r_obi_req <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb2obi_slave_adapter.sv
// Self-checking bench for ahb2obi_slave_adapter (default build): directed cases plus
// randomized single transfers against a transaction-level expectation model.
module tb_ahb2obi_slave_adapter;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    wire         hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] last_rd = 32'h0;

    // Single-slave bus: HREADYIN is this slave's own HREADYOUT.
    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb2obi_slave_adapter #(.ADDR_W(32), .ERR_UNALIGNED(1'b1)) dut (
        .hclk_i(hclk), .hresetn_i(hresetn), .hsel_i(hsel), .haddr_i(haddr),
        .htrans_i(htrans), .hwrite_i(hwrite), .hsize_i(hsize), .hwdata_i(hwdata),
        .hready_i(hready), .hreadyout_o(hreadyout), .hresp_o(hresp), .hrdata_o(hrdata),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
        .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge hclk);
        #1;
    endtask

    function automatic logic exp_bad(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b1;
        return (a % (32'd1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] sz, input logic [31:0] a);
        int nb;
        nb = 1 << sz;
        return 4'(((1 << nb) - 1) << (((a % 4) / nb) * nb));
    endfunction

    // One isolated AHB transfer against a scripted OBI slave, checked cycle by cycle.
    task automatic xfer(input logic we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int gdly, input int rdly,
                        input logic err, input logic [31:0] rd);
        cyc();
        hsel = 1'b1; htrans = 2'b10; haddr = a; hwrite = we; hsize = sz;
        obi_gnt = 1'b0; obi_rvalid = 1'b0;
        @(negedge hclk);
        chk("addr_rdy", {31'h0, hreadyout}, 32'h1);
        cyc();
        hsel = 1'b0; htrans = 2'b00; hwdata = wd;
        if (exp_bad(sz, a)) begin
            @(negedge hclk);
            chk("bad1_req", {31'h0, obi_req}, 32'h0);
            chk("bad1_rdy", {31'h0, hreadyout}, 32'h0);
            chk("bad1_resp", {31'h0, hresp}, 32'h1);
            cyc();
            @(negedge hclk);
            chk("bad2_req", {31'h0, obi_req}, 32'h0);
            chk("bad2_rdy", {31'h0, hreadyout}, 32'h1);
            chk("bad2_resp", {31'h0, hresp}, 32'h1);
        end else begin
            for (int g = 0; g <= gdly; g++) begin
                if (g > 0) cyc();
                obi_gnt = (g == gdly);
                @(negedge hclk);
                chk("req", {31'h0, obi_req}, 32'h1);
                chk("req_addr", obi_addr, a & 32'hFFFF_FFFC);
                chk("req_be", {28'h0, obi_be}, {28'h0, exp_be(sz, a)});
                chk("req_we", {31'h0, obi_we}, {31'h0, we});
                if (we) chk("req_wdata", obi_wdata, wd);
                chk("req_rdy", {31'h0, hreadyout}, 32'h0);
            end
            for (int r = 0; r <= rdly; r++) begin
                cyc();
                obi_gnt = 1'b0;
                obi_rvalid = (r == rdly);
                obi_rdata = (r == rdly) ? rd : $urandom;
                obi_err = (r == rdly) ? err : 1'($urandom);
                @(negedge hclk);
                chk("rsp_req", {31'h0, obi_req}, 32'h0);
                if (r < rdly || err) begin
                    chk("rsp_rdy", {31'h0, hreadyout}, 32'h0);
                    chk("rsp_resp", {31'h0, hresp}, 32'h0);
                end else begin
                    chk("done_rdy", {31'h0, hreadyout}, 32'h1);
                    chk("done_resp", {31'h0, hresp}, 32'h0);
                    if (!we) begin
                        last_rd = rd;
                        chk("done_rdata", hrdata, rd);
                    end
                end
            end
            if (err) begin
                cyc();
                obi_rvalid = 1'b0;
                @(negedge hclk);
                chk("err1_rdy", {31'h0, hreadyout}, 32'h0);
                chk("err1_resp", {31'h0, hresp}, 32'h1);
                cyc();
                @(negedge hclk);
                chk("err2_rdy", {31'h0, hreadyout}, 32'h1);
                chk("err2_resp", {31'h0, hresp}, 32'h1);
            end
        end
        cyc();
        obi_rvalid = 1'b0; obi_gnt = 1'b0;
        @(negedge hclk);
        chk("idle_rdy", {31'h0, hreadyout}, 32'h1);
        chk("idle_resp", {31'h0, hresp}, 32'h0);
        chk("idle_hold", hrdata, last_rd);
    endtask

    initial begin
        logic        rwe;
        logic [2:0]  rsz;
        logic [31:0] ra;

        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
        hsize = 3'd0; hwdata = '0; obi_gnt = 1'b0; obi_rvalid = 1'b0;
        obi_rdata = '0; obi_err = 1'b0;
        repeat (2) @(posedge hclk);
        @(negedge hclk);
        chk("rst_rdy", {31'h0, hreadyout}, 32'h1);
        chk("rst_resp", {31'h0, hresp}, 32'h0);
        chk("rst_rdata", hrdata, 32'h0);
        chk("rst_req", {31'h0, obi_req}, 32'h0);
        chk("rst_we", {31'h0, obi_we}, 32'h0);
        chk("rst_be", {28'h0, obi_be}, 32'h0);
        chk("rst_addr", obi_addr, 32'h0);
        cyc();
        hresetn = 1'b1;

        // Directed: word read, byte write, stalled grant, error response, bad transfers.
        xfer(1'b0, 3'd2, 32'h100, 32'h5555_AAAA, 0, 0, 1'b0, 32'hDEAD_BEEF);
        xfer(1'b1, 3'd0, 32'h203, 32'h0000_AB00, 0, 0, 1'b0, 32'h0);
        xfer(1'b0, 3'd2, 32'h340, 32'h0, 3, 0, 1'b0, 32'h1234_5678);
        xfer(1'b0, 3'd1, 32'h402, 32'h0, 0, 1, 1'b1, 32'hBAD0_BAD0);
        xfer(1'b1, 3'd1, 32'h101, 32'hFFFF_FFFF, 0, 0, 1'b0, 32'h0);
        xfer(1'b0, 3'd3, 32'h100, 32'h0, 0, 0, 1'b0, 32'h0);

        // Back-to-back reads 0x0 and 0x4: second address phase overlaps the first data phase.
        cyc();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
        @(negedge hclk);
        chk("b2b_a1_rdy", {31'h0, hreadyout}, 32'h1);
        cyc();
        haddr = 32'h4; obi_gnt = 1'b1;
        @(negedge hclk);
        chk("b2b_req1", {31'h0, obi_req}, 32'h1);
        chk("b2b_addr1", obi_addr, 32'h0);
        chk("b2b_stall", {31'h0, hreadyout}, 32'h0);
        cyc();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hCAFE_0001; obi_err = 1'b0;
        @(negedge hclk);
        chk("b2b_done1", {31'h0, hreadyout}, 32'h1);
        chk("b2b_data1", hrdata, 32'hCAFE_0001);
        cyc();
        hsel = 1'b0; htrans = 2'b00; obi_rvalid = 1'b0; obi_gnt = 1'b1;
        @(negedge hclk);
        chk("b2b_req2", {31'h0, obi_req}, 32'h1);
        chk("b2b_addr2", obi_addr, 32'h4);
        cyc();
        obi_gnt = 1'b0; obi_rvalid = 1'b1; obi_rdata = 32'hCAFE_0002;
        @(negedge hclk);
        chk("b2b_done2", {31'h0, hreadyout}, 32'h1);
        chk("b2b_data2", hrdata, 32'hCAFE_0002);
        last_rd = 32'hCAFE_0002;
        cyc();
        obi_rvalid = 1'b0;
        @(negedge hclk);
        chk("b2b_idle", {31'h0, hreadyout}, 32'h1);

        // Randomized single transfers.
        for (int i = 0; i < 40; i++) begin
            rwe = 1'($urandom);
            rsz = ($urandom % 8 == 0) ? 3'd3 : 3'($urandom % 3);
            ra  = $urandom & 32'h0000_FFFF;
            if ($urandom % 3 != 0 && rsz <= 3'd2) ra = ra & ~((32'd1 << rsz) - 1);
            xfer(rwe, rsz, ra, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                 ($urandom % 5 == 0), $urandom);
        end

        // Reset while waiting for an OBI response; the late response must be ignored.
        cyc();
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h300; hwrite = 1'b1; hsize = 3'd2;
        cyc();
        hsel = 1'b0; htrans = 2'b00; obi_gnt = 1'b1;
        cyc();
        obi_gnt = 1'b0;
        #2 hresetn = 1'b0;
        #1;
        chk("arst_rdy", {31'h0, hreadyout}, 32'h1);
        chk("arst_resp", {31'h0, hresp}, 32'h0);
        chk("arst_rdata", hrdata, 32'h0);
        chk("arst_req", {31'h0, obi_req}, 32'h0);
        chk("arst_we", {31'h0, obi_we}, 32'h0);
        chk("arst_be", {28'h0, obi_be}, 32'h0);
        chk("arst_addr", obi_addr, 32'h0);
        cyc();
        hresetn = 1'b1;
        cyc();
        obi_rvalid = 1'b1; obi_rdata = 32'h7777_7777;
        @(negedge hclk);
        chk("post_rst_rdy", {31'h0, hreadyout}, 32'h1);
        chk("post_rst_rdata", hrdata, 32'h0);
        cyc();
        obi_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
